apb_slave_mem: RTL

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

---
 rtl/apb_slave_pkg.sv | 17 +
 rtl/apb_slave_mem_if.sv | 26 ++
 rtl/apb_wait_ctr.sv | 40 ++++
 rtl/apb_slave_mem.sv | 111 +++++++++++
 4 files changed

// File: rtl/apb_slave_pkg.sv
// Shared types and default parameters for the APB slave memory.
// Latency: n/a (types only). Backpressure: n/a.
// Holds the FSM state encoding and wait-counter width.
package apb_slave_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int ADDR_W_DEF      = 8;
    localparam int DATA_W_DEF      = 8;
    localparam int DEPTH_DEF       = 64;
    localparam int WAIT_CYCLES_DEF = 2;
    localparam int CTR_W           = 4;

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB completer-side bus bundle with requester and completer views.
// Latency: n/a (wires only). Backpressure: pready driven by the completer.
// Clock and reset stay outside the bundle.
interface apb_slave_mem_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_wait_ctr.sv
// 4-bit wait-state counter: load, clear, decrement-to-zero, zero flag.
// Latency: count updates one pclk edge after a control pulse.
// Backpressure: none; decrement saturates at zero.
module apb_wait_ctr
    import apb_slave_pkg::*;
(
    input  logic             pclk,
    input  logic             presetn,
    input  logic             load_i,
    input  logic [CTR_W-1:0] load_val_i,
    input  logic             dec_i,
    input  logic             clr_i,
    output logic             zero_o
);

    logic [CTR_W-1:0] cnt_q;
    logic [CTR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer backed by a DEPTH-word register memory with error on out-of-range address.
// Latency: pready rises in access cycle WAIT_CYCLES+1; writes land on the completion edge.
// Backpressure: holds pready low for WAIT_CYCLES access cycles; psel drop aborts.
module apb_slave_mem
    import apb_slave_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic          pclk,
    input  logic          presetn,
    apb_slave_mem_if.slave apb
);

    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [CTR_W-1:0]  WAIT_L  = CTR_W'(WAIT_CYCLES);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              ctr_load, ctr_dec, ctr_clr, ctr_zero;
    logic              mem_we;
    logic              addr_ok;
    logic [IDX_W-1:0]  idx;
    logic              pready_w;

    // Full-width unsigned compare so out-of-range addresses never alias into memory.
    assign addr_ok = ({1'b0, addr_q} < DEPTH_L);
    assign idx     = addr_q[IDX_W-1:0];

    apb_wait_ctr u_wait_ctr (
        .pclk       (pclk),
        .presetn    (presetn),
        .load_i     (ctr_load),
        .load_val_i (WAIT_L),
        .dec_i      (ctr_dec),
        .clr_i      (ctr_clr),
        .zero_o     (ctr_zero)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        ctr_load = 1'b0;
        ctr_dec  = 1'b0;
        ctr_clr  = 1'b0;
        mem_we   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (apb.psel && !apb.penable) begin
                    state_d  = ACCESS;
                    addr_d   = apb.paddr;
                    pwrite_d = apb.pwrite;
                    pwdata_d = apb.pwdata;
                    ctr_load = 1'b1;
                end
            end
            ACCESS: begin
                if (!apb.psel) begin
                    state_d = IDLE;
                    ctr_clr = 1'b1;
                end else if (!ctr_zero) begin
                    ctr_dec = apb.penable;
                end else begin
                    state_d = IDLE;
                    mem_we  = pwrite_q && addr_ok;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[idx] <= pwdata_q;
        end
    end

    // Outputs depend only on registered state, so no input reaches them combinationally.
    assign pready_w    = (state_q == ACCESS) && ctr_zero;
    assign apb.pready  = pready_w;
    assign apb.pslverr = pready_w && !addr_ok;
    assign apb.prdata  = (pready_w && !pwrite_q && addr_ok) ? mem_q[idx] : '0;

endmodule
